sfm_cast_out_packer: RTL and testbench
======================================

# sfm_cast_out_packer

Registered float-to-integer output caster for the softmax datapath, sitting between the normalisation stage and the output streamer. It converts every FP lane of an accepted beat to a signed or unsigned fixed-point integer with round-half-away-from-zero and saturation. It then packs the narrow results of several consecutive input beats into one full-width output beat, so the streamer always writes dense words. A flush input emits a trailing partial beat with exact byte strobes.

## Interface
- DATA_WIDTH, DATA_W: stream data width in bits; multiple of FP_WIDTH.
- FPFORMAT, FPFORMAT_IN: input float format; gives FP_WIDTH, EXP_BITS, MAN_BITS, BIAS.
- INT_WIDTH, INT_W: output integer width; power of two, 8 ≤ INT_WIDTH ≤ FP_WIDTH.
- Derived: LANES = DATA_WIDTH/FP_WIDTH; P = FP_WIDTH/INT_WIDTH (pack ratio); SLOT_W = LANES*INT_WIDTH.
- clk_i  in  1  clock; every register samples on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear; empties the buffer and drops any pending flush.
- ctrl_i  in  cast_ctrl_t  enable, is_signed, int_bits; stable while the buffer is non-empty.
- flush_i  in  1  single-cycle request to emit the buffered partial beat.
- stream_i  sink  DATA_WIDTH  FP input beats, hwpe valid/ready/data/strb.
- stream_o  source  DATA_WIDTH  packed integer output beats.

## Operation
- Per lane: S = INT_WIDTH − int_bits − is_signed; q = x·2^S. Round q's magnitude half away from zero, then apply the sign.
- Saturation: unsigned range [0, 2^INT_WIDTH−1]; signed range [−2^(INT_WIDTH−1), 2^(INT_WIDTH−1)−1].
- Negative x with is_signed=0 gives 0. Zero and subnormal inputs give 0. ±Inf saturates by sign. NaN gives 0.
- Lane strobe: all INT_WIDTH/8 bits set iff all FP_WIDTH/8 input strobe bits of that lane are set; otherwise all cleared.
- Buffer state: pack_q (DATA_WIDTH), strb_q (DATA_WIDTH/8), cnt_q (0..P), flush_q.
- Beat k since the last emission writes slot k, bits [k·SLOT_W +: SLOT_W], with lanes in ascending order.
- enable=0 is passthrough: P is treated as 1, and data and strb are copied unchanged into slot 0.
- stream_o.valid = (cnt_q == P_eff) or (flush_q and cnt_q > 0).
- stream_i.ready = !stream_o.valid or stream_o.ready.
- An output handshake with no input handshake sets cnt_q to 0, clears pack_q and strb_q, and clears flush_q.
- An output handshake together with an input handshake writes the new beat to slot 0, sets cnt_q to 1, and clears flush_q.
- flush_i while cnt_q = 0 and no input handshake is ignored.
- flush_i together with an input handshake includes that beat before the flush.
- Partial beats carry data 0 and strb 0 in unfilled slots.
- clear_i has priority over every other event. rst_i resets all state asynchronously at any time, mid-packet included.

## Timing
- Reset values: stream_o.valid=0, stream_o.data=0, stream_o.strb=0, stream_i.ready=1, cnt_q=0, flush_q=0.
- Latency: the P-th accepted beat (or the beat carrying a flush, or a flush alone) is visible on stream_o one cycle later.
- Full throughput: one input beat per cycle at any ratio. With stream_o.ready held high there are no bubbles, including back-to-back full beats.
- stream_o.valid depends only on registers and never on stream_o.ready. Once valid is raised, data and strb stay stable until the handshake.
- Backpressure: while stream_o.valid=1 and stream_o.ready=0, stream_i.ready=0.
- The only combinational path is stream_o.ready → stream_i.ready.

## Configuration
- SFM_CAST_OUT_PACK_EN defined: packing as described above, P = FP_WIDTH/INT_WIDTH.
- SFM_CAST_OUT_PACK_EN undefined:
  - P is fixed to 1, and each input beat produces one output beat in slot 0.
  - Upper DATA_WIDTH−SLOT_W bits carry data 0 and strb 0.
  - flush_i is ignored.
  - Latency and handshake are unchanged.

## Test plan
All scenarios use BF16, DATA_WIDTH=64, INT_WIDTH=8 (LANES=4, P=2).
- Unsigned, int_bits=0:
  - lanes {0.5, 1.0, 2^-9, −0.25} → bytes {0x80, 0xFF, 0x01, 0x00}.
  - Packed with a second beat of 0.5 in every lane → data 0x8080_8080_0001_FF80, strb 0xFF.
- Signed, int_bits=0: lanes {−0.5, 0.5, −1.0, +Inf} → {0xC0, 0x40, 0x80, 0x7F}.
- Partial flush: one beat accepted, then flush_i pulsed → one output beat next cycle, strb 0x0F, upper 32 bits zero, cnt_q returns to 0.
- Backpressure: stream_o.ready held low for 5 cycles with the buffer full → stream_i.ready=0 and output held stable; release gives one beat and input acceptance resumes the same cycle.
- Streaming: 8 input beats with stream_o.ready=1 → exactly 4 output beats on consecutive odd cycles, no drops.
- Reset and clear: rst_i asserted with cnt_q=1 and flush_q=1 → all outputs zero; clear_i gives the same result synchronously; enable=0 passthrough beat is reproduced bit-exact.

Source files
------------

// File: rtl/sfm_cast_out_packer.sv
// sfm_cast_out_packer: FP-to-int caster (round half away from zero, saturating) that packs narrow beats into dense words.
// Define SFM_CAST_OUT_PACK_EN to pack FP_WIDTH/INT_WIDTH beats per output word; otherwise each beat is emitted alone.
module sfm_cast_out_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int EXP_BITS   = 8,
  parameter int MAN_BITS   = 7,
  parameter int INT_WIDTH  = 8,
  localparam int IBW       = $clog2(INT_WIDTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    ctrl_enable_i,
  input  logic                    ctrl_is_signed_i,
  input  logic [IBW-1:0]          ctrl_int_bits_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_strb_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [DATA_WIDTH/8-1:0] out_strb_o
);
  localparam int FP_WIDTH = 1 + EXP_BITS + MAN_BITS;
  localparam int BIAS     = (1 << (EXP_BITS - 1)) - 1;
  localparam int LANES    = DATA_WIDTH / FP_WIDTH;
  localparam int SLOT_W   = LANES * INT_WIDTH;
  localparam int SB       = SLOT_W / 8;
  localparam int FB       = FP_WIDTH / 8;
  localparam int IB       = INT_WIDTH / 8;
  localparam int TW       = MAN_BITS + INT_WIDTH + 3;
`ifdef SFM_CAST_OUT_PACK_EN
  localparam logic PACK_EN = 1'b1;
`else
  localparam logic PACK_EN = 1'b0;
`endif
  localparam int P  = PACK_EN ? FP_WIDTH / INT_WIDTH : 1;
  localparam int CW = $clog2(P + 1);

  logic [DATA_WIDTH-1:0]   pack_q, pack_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic [CW-1:0]           cnt_q, cnt_d, p_eff;
  logic                    flush_q, flush_d;
  logic [SLOT_W-1:0]       slot_data;
  logic [SB-1:0]           slot_strb;
  logic                    in_hs, out_hs;

  // Mantissa carries one extra fraction bit so the final +1>>1 rounds half away from zero on the magnitude.
  function automatic logic [INT_WIDTH-1:0] cast_lane(input logic [FP_WIDTH-1:0] x, input logic sgn,
                                                     input logic [IBW-1:0] ib);
    logic                 neg, ovf;
    logic [EXP_BITS-1:0]  e;
    logic [MAN_BITS-1:0]  m;
    logic [TW-1:0]        t, mag;
    logic [INT_WIDTH-1:0] lim, min_s;
    int                   sh;
    neg   = x[FP_WIDTH-1];
    e     = x[FP_WIDTH-2 -: EXP_BITS];
    m     = x[MAN_BITS-1:0];
    sh    = int'(e) - BIAS - MAN_BITS + INT_WIDTH - int'(ib) - int'(sgn);
    ovf   = (e == '1) || (sh > INT_WIDTH);
    t     = TW'({1'b1, m, 1'b0});
    t     = (sh >= 0) ? t << sh : t >> (-sh);
    mag   = (t + TW'(1)) >> 1;
    min_s = {1'b1, {(INT_WIDTH-1){1'b0}}};
    lim   = sgn ? ~min_s : '1;
    if (e == '0 || (e == '1 && m != '0) || (neg && !sgn)) return '0;
    if (neg) return (ovf || mag >= TW'(min_s)) ? min_s : INT_WIDTH'(-mag);
    return (ovf || mag > TW'(lim)) ? lim : mag[INT_WIDTH-1:0];
  endfunction

  always_comb begin
    slot_data = '0;
    slot_strb = '0;
    for (int l = 0; l < LANES; l++) begin
      slot_data[l*INT_WIDTH +: INT_WIDTH] = cast_lane(in_data_i[l*FP_WIDTH +: FP_WIDTH], ctrl_is_signed_i, ctrl_int_bits_i);
      slot_strb[l*IB +: IB] = {IB{&in_strb_i[l*FB +: FB]}};
    end
  end

  assign p_eff       = (PACK_EN && ctrl_enable_i) ? CW'(P) : CW'(1);
  assign out_valid_o = (cnt_q == p_eff) || (flush_q && cnt_q != '0);
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign in_hs       = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_o && out_ready_i;
  assign out_data_o  = pack_q;
  assign out_strb_o  = strb_q;

  always_comb begin
    pack_d  = out_hs ? '0 : pack_q;
    strb_d  = out_hs ? '0 : strb_q;
    cnt_d   = out_hs ? '0 : cnt_q;
    flush_d = flush_q && !out_hs;
    if (in_hs) begin
      if (!ctrl_enable_i) begin
        pack_d = in_data_i;
        strb_d = in_strb_i;
      end else begin
        for (int k = 0; k < P; k++) begin
          if (CW'(k) == cnt_d) begin
            pack_d[k*SLOT_W +: SLOT_W] = slot_data;
            strb_d[k*SB +: SB]         = slot_strb;
          end
        end
      end
      cnt_d = cnt_d + CW'(1);
    end
    // A flush only sticks when something is buffered; the beat accepted this cycle counts.
    flush_d = PACK_EN && (flush_d || flush_i) && cnt_d != '0;
    if (clear_i) begin
      pack_d  = '0;
      strb_d  = '0;
      cnt_d   = '0;
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_q  <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_sfm_cast_out_packer.sv
// tb_sfm_cast_out_packer: randomized bench for the BF16 -> int8 caster/packer with a real-arithmetic reference model.
module tb_sfm_cast_out_packer;
`ifdef SFM_CAST_OUT_PACK_EN
  localparam int PM = 2;
`else
  localparam int PM = 1;
`endif

  typedef struct packed { logic [63:0] d; logic [7:0] s; } beat_t;

  logic        clk = 1'b0, rst = 1'b0, clear = 1'b0;
  logic        en = 1'b1, sg = 1'b0, flush = 1'b0;
  logic [3:0]  ib = '0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [63:0] in_data = '0, out_data;
  logic [7:0]  in_strb = '0, out_strb;

  int          n_checks = 0, n_fail = 0;
  beat_t       eq[$];
  logic [63:0] g_d = '0;
  logic [7:0]  g_s = '0;
  int          g_n = 0;
  logic        o_v, o_r, e_v, e_r;
  logic [63:0] o_d, e_d;
  logic [7:0]  o_s, e_s;

  sfm_cast_out_packer #(.DATA_WIDTH(64), .EXP_BITS(8), .MAN_BITS(7), .INT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .ctrl_enable_i(en), .ctrl_is_signed_i(sg),
    .ctrl_int_bits_i(ib), .flush_i(flush), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_strb_i(in_strb), .in_ready_o(in_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_strb_o(out_strb));

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_cast(input logic [15:0] x, input logic s_en, input int ibits);
    logic s; logic [7:0] e; logic [6:0] m;
    real v, hi, lo; int iv;
    s = x[15]; e = x[14:7]; m = x[6:0];
    if (e == 8'h00 || (e == 8'hFF && m != 0)) return 8'h00;
    hi = s_en ? 127.0 : 255.0;
    lo = s_en ? -128.0 : 0.0;
    if (e == 8'hFF) v = s ? lo : hi;
    else begin
      v = (1.0 + real'(m) / 128.0) * (2.0 ** (real'(e) - 127.0 + real'(8 - ibits - int'(s_en))));
      v = $floor(v + 0.5);
      if (s) v = -v;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
    end
    iv = int'(v);
    return iv[7:0];
  endfunction

  function automatic void model_close();
    beat_t b;
    b.d = g_d; b.s = g_s;
    eq.push_back(b);
    g_d = '0; g_s = '0; g_n = 0;
  endfunction

  function automatic void model_accept(input logic [63:0] d, input logic [7:0] s);
    beat_t b;
    if (!en) begin
      b.d = d; b.s = s;
      eq.push_back(b);
      return;
    end
    for (int l = 0; l < 4; l++) begin
      g_d[g_n*32 + l*8 +: 8] = ref_cast(d[l*16 +: 16], sg, int'(ib));
      g_s[g_n*4 + l]         = &s[l*2 +: 2];
    end
    g_n++;
    if (g_n == PM) model_close();
  endfunction

  function automatic void model_reset();
    eq.delete();
    g_d = '0; g_s = '0; g_n = 0;
  endfunction

  function automatic logic [15:0] rand_fp();
    logic s; logic [6:0] m; int k;
    s = 1'($urandom); m = 7'($urandom); k = $urandom_range(0, 9);
    if (k == 0) return {s, 8'h00, m};
    if (k == 1) return {s, 8'hFF, m};
    if (k == 2) return 16'($urandom);
    return {s, 8'(115 + $urandom_range(0, 16)), m};
  endfunction

  function automatic logic [63:0] rand_beat();
    return {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
  endfunction

  function automatic logic [7:0] rand_strb();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
  endfunction

  // Drives one cycle, samples DUT and model expectations mid-cycle, then advances the model.
  task automatic run_cycle(input logic v, input logic [63:0] d, input logic [7:0] s, input logic f,
                           input logic o, input logic c);
    in_valid = v; in_data = d; in_strb = s; flush = f; out_ready = o; clear = c;
    @(negedge clk);
    e_v = eq.size() > 0;
    e_d = e_v ? eq[0].d : g_d;
    e_s = e_v ? eq[0].s : g_s;
    e_r = !e_v || o;
    o_v = out_valid; o_d = out_data; o_s = out_strb; o_r = in_ready;
    if (c) model_reset();
    else begin
      if (e_v && o) void'(eq.pop_front());
      if (v && e_r) model_accept(d, s);
      if (f) model_flush();
    end
    @(posedge clk); #1;
  endtask

  function automatic void model_flush();
    if (PM > 1 && g_n > 0) model_close();
  endfunction

  task automatic test_reset();
    run_cycle(0, '0, '0, 0, 0, 0);
    n_checks++;
    if ({o_v, o_d, o_s, o_r} !== {1'b0, 64'h0, 8'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%h s=%h r=%b want v=0 d=0 s=0 r=1", o_v, o_d, o_s, o_r);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] beats [3];
    logic [63:0] lit_d;
    logic [7:0]  lit_s;
    beats[0] = 64'hBE80_3B00_3F80_3F00;
    beats[1] = 64'h3F00_3F00_3F00_3F00;
    beats[2] = '0;
    lit_d = (PM == 2) ? 64'h8080_8080_0001_FF80 : 64'h0000_0000_8080_8080;
    lit_s = (PM == 2) ? 8'hFF : 8'h0F;
    en = 1; sg = 0; ib = 0;
    for (int i = 0; i < 3; i++) begin
      run_cycle(i < 2, beats[i], 8'hFF, 0, 1, 0);
      n_checks++;
      if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
        n_fail++;
        $display("FAIL unsigned_sb[%0d]: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
                 i, o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
      end
    end
    n_checks++;
    if ({o_v, o_d, o_s} !== {1'b1, lit_d, lit_s}) begin
      n_fail++;
      $display("FAIL unsigned_packed: got v=%b d=%h s=%h want v=1 d=%h s=%h", o_v, o_d, o_s, lit_d, lit_s);
    end
    run_cycle(0, '0, '0, 0, 1, 0);
  endtask

  task automatic test_signed();
    en = 1; sg = 1; ib = 0;
    run_cycle(1, 64'h7F80_BF80_3F00_BF00, 8'hFF, 1, 1, 0);
    run_cycle(0, '0, '0, 0, 1, 0);
    n_checks++;
    if ({o_v, o_d, o_s} !== {1'b1, 64'h0000_0000_7F80_40C0, 8'h0F}) begin
      n_fail++;
      $display("FAIL signed_flush_beat: got v=%b d=%h s=%h want v=1 d=000000007f8040c0 s=0f", o_v, o_d, o_s);
    end
    n_checks++;
    if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
      n_fail++;
      $display("FAIL signed_sb: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
               o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
    end
  endtask

  task automatic test_partial_flush();
    int seen;
    seen = 0;
    en = 1; sg = 0; ib = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(i == 0, 64'h3F00_3F00_3F00_3F00, 8'hFF, i == 1, 1, 0);
      n_checks++;
      if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
        n_fail++;
        $display("FAIL partial_sb[%0d]: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
                 i, o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
      end
      if (o_v) begin
        seen++;
        n_checks++;
        if ({o_s, o_d[63:32]} !== {8'h0F, 32'h0}) begin
          n_fail++;
          $display("FAIL partial_strb: got s=%h upper=%h want s=0f upper=0", o_s, o_d[63:32]);
        end
      end
    end
    n_checks++;
    if (seen != 1 || o_v !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_count: got beats=%0d final_v=%b want beats=1 final_v=0", seen, o_v);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] hold;
    hold = rand_beat();
    en = 1; sg = 1'($urandom); ib = 4'($urandom_range(0, 8));
    for (int i = 0; i < PM + 6; i++) begin
      run_cycle(1, (i < PM) ? rand_beat() : hold, 8'hFF, 0, i == PM + 5, 0);
      n_checks++;
      if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
        n_fail++;
        $display("FAIL bp_sb[%0d]: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
                 i, o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
      end
      if (i >= PM) begin
        n_checks++;
        if ({o_v, o_r} !== {1'b1, i == PM + 5}) begin
          n_fail++;
          $display("FAIL bp_ready[%0d]: got v=%b r=%b want v=1 r=%b", i, o_v, o_r, i == PM + 5);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, '0, '0, i == 0, 1, 0);
      n_checks++;
      if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
                 i, o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
      end
    end
  endtask

  task automatic test_stream();
    int outs, bubbles;
    outs = 0; bubbles = 0;
    en = 1; sg = 0; ib = 4'($urandom_range(0, 4));
    for (int i = 0; i < 10; i++) begin
      run_cycle(i < 8, rand_beat(), rand_strb(), 0, 1, 0);
      n_checks++;
      if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
        n_fail++;
        $display("FAIL stream_sb[%0d]: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
                 i, o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
      end
      if (o_v) outs++;
      if (i < 8 && !o_r) bubbles++;
    end
    n_checks++;
    if (outs != 8 / PM || bubbles != 0) begin
      n_fail++;
      $display("FAIL stream_count: got outs=%0d stalls=%0d want outs=%0d stalls=0", outs, bubbles, 8 / PM);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (eq.size() == 0 && g_n == 0 && $urandom_range(0, 5) == 0) begin
        en = ($urandom_range(0, 4) != 0); sg = 1'($urandom); ib = 4'($urandom_range(0, 8));
      end
      run_cycle(1'($urandom), rand_beat(), rand_strb(), $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      n_checks++;
      if ({o_v, o_d, o_s, o_r} !== {e_v, e_d, e_s, e_r}) begin
        n_fail++;
        $display("FAIL random_sb[%0d]: got v=%b d=%h s=%h r=%b want v=%b d=%h s=%h r=%b",
                 i, o_v, o_d, o_s, o_r, e_v, e_d, e_s, e_r);
      end
    end
    for (int i = 0; i < 3; i++) run_cycle(0, '0, '0, 1, 1, 0);
  endtask

  task automatic test_reset_clear();
    en = 1; sg = 0; ib = 0;
    run_cycle(1, rand_beat(), 8'hFF, 0, 0, 0);
    run_cycle(0, '0, '0, 1, 0, 0);
    rst = 1;
    #2;
    n_checks++;
    if ({out_valid, out_data, out_strb, in_ready} !== {1'b0, 64'h0, 8'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h s=%h r=%b want v=0 d=0 s=0 r=1", out_valid, out_data, out_strb, in_ready);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    run_cycle(1, rand_beat(), 8'hFF, 0, 0, 0);
    run_cycle(0, '0, '0, 1, 0, 0);
    run_cycle(1, rand_beat(), 8'hFF, 0, 0, 1);
    run_cycle(0, '0, '0, 0, 0, 0);
    n_checks++;
    if ({o_v, o_d, o_s, o_r} !== {1'b0, 64'h0, 8'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL sync_clear: got v=%b d=%h s=%h r=%b want v=0 d=0 s=0 r=1", o_v, o_d, o_s, o_r);
    end
  endtask

  task automatic test_passthrough();
    logic [63:0] d;
    logic [7:0]  s;
    en = 0; sg = 1'($urandom); ib = 4'($urandom_range(0, 8));
    for (int i = 0; i < 3; i++) begin
      d = 64'({$urandom, $urandom}); s = 8'($urandom);
      run_cycle(1, d, s, 0, 1, 0);
      run_cycle(0, '0, '0, 0, 1, 0);
      n_checks++;
      if ({o_v, o_d, o_s} !== {1'b1, d, s}) begin
        n_fail++;
        $display("FAIL passthrough[%0d]: got v=%b d=%h s=%h want v=1 d=%h s=%h", i, o_v, o_d, o_s, d, s);
      end
    end
    en = 1;
  endtask

  initial begin
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_partial_flush();
    test_backpressure();
    test_stream();
    test_reset_clear();
    test_passthrough();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end
endmodule
